// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: EX-stage issue/result bundle for the HI/LO multiply-divide unit.
interface hilo_muldiv_unit_if;
    logic        valid_in;
    logic [3:0]  op_in;
    logic [31:0] data1_in;
    logic [31:0] data2_in;
    logic [31:0] data_out;
    logic        busy_out;
    logic        stall_out;
    logic        done_out;
    modport master (output valid_in, op_in, data1_in, data2_in,
                    input  data_out, busy_out, stall_out, done_out);
    modport slave  (input  valid_in, op_in, data1_in, data2_in,
                    output data_out, busy_out, stall_out, done_out);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: 32-cycle unsigned shift-add multiply / restoring divide owning HI/LO.
module hilo_muldiv_unit #(
    parameter int ITER = 32
) (
    input logic clk_in,
    input logic rst_in,
    hilo_muldiv_unit_if.slave bus
);
    localparam logic [3:0] OP_MFHI = 4'd3, OP_MFLO = 4'd4, OP_MULT = 4'd5,
                           OP_DIV = 4'd8, OP_MTHI = 4'd9, OP_MTLO = 4'd10;
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t      state, state_d;
    logic [4:0]  cnt, cnt_d;
    logic [63:0] acc, acc_d, step;
    logic [31:0] opnd, opnd_d, hi, hi_d, lo, lo_d;
    logic        done, done_d, recog, busy, accept;
    logic [32:0] mul_sum, div_diff;
    assign recog  = bus.op_in inside {OP_MFHI, OP_MFLO, OP_MULT, OP_DIV, OP_MTHI, OP_MTLO};
    assign busy   = state != IDLE;
    assign accept = bus.valid_in & recog & ~busy;
    assign bus.busy_out  = busy;
    assign bus.stall_out = bus.valid_in & busy & recog;
    assign bus.done_out  = done;
    assign bus.data_out  = (bus.valid_in && bus.op_in == OP_MFHI) ? hi :
                           (bus.valid_in && bus.op_in == OP_MFLO) ? lo : 32'd0;
    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        acc_d    = acc;
        opnd_d   = opnd;
        hi_d     = hi;
        lo_d     = lo;
        done_d   = 1'b0;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_diff = acc[63:31] - {1'b0, opnd};
        step     = (state == MUL) ? {mul_sum, acc[31:1]} :
                   div_diff[32]   ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
        if (state == IDLE) begin
            if (accept && bus.op_in == OP_MULT) begin
                state_d = MUL;
                acc_d   = {32'd0, bus.data2_in};
                opnd_d  = bus.data1_in;
            end else if (accept && bus.op_in == OP_DIV) begin
                state_d = DIV;
                acc_d   = {32'd0, bus.data1_in};
                opnd_d  = bus.data2_in;
            end
            hi_d = (accept && bus.op_in == OP_MTHI) ? bus.data1_in : hi;
            lo_d = (accept && bus.op_in == OP_MTLO) ? bus.data1_in : lo;
        end else begin
            acc_d = step;
            cnt_d = cnt + 5'd1;
            if (cnt == 5'(ITER - 1)) begin
                state_d = IDLE;
                cnt_d   = 5'd0;
                hi_d    = step[63:32];
                lo_d    = step[31:0];
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt   <= 5'd0;
            acc   <= 64'd0;
            opnd  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            acc   <= acc_d;
            opnd  <= opnd_d;
            hi    <= hi_d;
            lo    <= lo_d;
            done  <= done_d;
        end
    end
endmodule
